approx_max_pipe: RTL and testbench

//  Streaming, parametrised approximate two-operand max unit; successor to the

---
 rtl/approx_max_pkg.sv | 21 ++
 rtl/approx_max_cmp.sv | 25 ++
 rtl/approx_max_pipe.sv | 158 +++++++++++++++
 tb/tb_approx_max_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_max_pkg.sv
// Shared types and the masked greater-than helper used by the approximate max datapath.
// Operands are zero-extended to MAX_W bits before comparison, so any WIDTH up to 32 works.
package approx_max_pkg;

    localparam int MAX_W = 32;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    // Returns 1 when b is strictly greater than a once the low 'trunc' bits are dropped.
    function automatic logic gt_masked(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      trunc
    );
        return (b >> trunc) > (a >> trunc);
    endfunction

endpackage

// File: rtl/approx_max_cmp.sv
// Combinational operand compare: exact and truncated selections side by side.
// Ties select A in both modes.
module approx_max_cmp
    import approx_max_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int TRUNC = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             sel_exact,
    output logic             sel_approx
);

    localparam int unsigned TRUNC_U = TRUNC;

    logic [MAX_W-1:0] a_ext;
    logic [MAX_W-1:0] b_ext;

    assign a_ext      = MAX_W'(a);
    assign b_ext      = MAX_W'(b);
    assign sel_exact  = gt_masked(a_ext, b_ext, 0);
    assign sel_approx = gt_masked(a_ext, b_ext, TRUNC_U);

endmodule

// File: rtl/approx_max_pipe.sv
// Two-stage valid/ready approximate max unit with per-frame running max and a
// saturating approx-vs-exact mismatch counter.
module approx_max_pipe
    import approx_max_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int TRUNC = 2,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic             out_sel,
    output logic             out_last,
    output logic [WIDTH-1:0] out_frame_max,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned TRUNC_U = TRUNC;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        mode_e            mode;
        logic             last;
        logic             sel_exact;
        logic             sel_approx;
    } s1_t;

    s1_t              s1_q;
    s1_t              s1_d;
    logic             s1_valid;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_max;
    logic             s2_sel;
    logic             s2_last;
    logic [WIDTH-1:0] s2_fmax;

    logic [WIDTH-1:0] acc;
    logic [ERR_W-1:0] err_q;

    logic             sel_exact_in;
    logic             sel_approx_in;

    logic             in_fire;
    logic             out_fire;
    logic             s2_load;

    logic             sel_mode;
    logic [WIDTH-1:0] max_mode;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] acc_next;
    logic             fm_upd;
    logic             mismatch;
    int unsigned      fm_trunc;

    approx_max_cmp #(
        .WIDTH (WIDTH),
        .TRUNC (TRUNC)
    ) u_cmp (
        .a          (in_a),
        .b          (in_b),
        .sel_exact  (sel_exact_in),
        .sel_approx (sel_approx_in)
    );

    assign out_fire = s2_valid & out_ready;
    assign s2_load  = s1_valid & (~s2_valid | out_ready);
    assign in_ready = ~rst & (~s1_valid | s2_load);
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        s1_d            = '0;
        s1_d.a          = in_a;
        s1_d.b          = in_b;
        s1_d.mode       = approx_en ? MODE_APPROX : MODE_EXACT;
        s1_d.last       = in_last;
        s1_d.sel_exact  = sel_exact_in;
        s1_d.sel_approx = sel_approx_in;
    end

    // A frame's last result leaving S2 in the same cycle as a new beat loads
    // means the incoming beat must already see an empty accumulator.
    always_comb begin
        sel_mode = '0;
        max_mode = '0;
        acc_base = '0;
        acc_next = '0;
        fm_upd   = '0;
        mismatch = '0;
        fm_trunc = '0;

        sel_mode = (s1_q.mode == MODE_APPROX) ? s1_q.sel_approx : s1_q.sel_exact;
        max_mode = sel_mode ? s1_q.b : s1_q.a;
        acc_base = (out_fire & s2_last) ? '0 : acc;
        fm_trunc = (s1_q.mode == MODE_APPROX) ? TRUNC_U : 32'd0;
        fm_upd   = gt_masked(MAX_W'(acc_base), MAX_W'(max_mode), fm_trunc);
        acc_next = fm_upd ? max_mode : acc_base;
        mismatch = (s1_q.mode == MODE_APPROX) & (s1_q.sel_approx != s1_q.sel_exact);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s2_valid <= 1'b0;
            s2_max   <= '0;
            s2_sel   <= 1'b0;
            s2_last  <= 1'b0;
            s2_fmax  <= '0;
            acc      <= '0;
            err_q    <= '0;
        end else begin
            if (in_fire) begin
                s1_q     <= s1_d;
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_max   <= max_mode;
                s2_sel   <= sel_mode;
                s2_last  <= s1_q.last;
                s2_fmax  <= acc_next;
                acc      <= acc_next;
                if (mismatch && (err_q != '1)) begin
                    err_q <= err_q + ERR_W'(1);
                end
            end else begin
                if (out_fire) begin
                    s2_valid <= 1'b0;
                end
                if (out_fire && s2_last) begin
                    acc <= '0;
                end
            end
        end
    end

    assign out_valid     = s2_valid;
    assign out_max       = s2_max;
    assign out_sel       = s2_sel;
    assign out_last      = s2_last;
    assign out_frame_max = s2_fmax;
    assign err_cnt       = err_q;

endmodule

// File: tb/tb_approx_max_pipe.sv
// Randomized and directed bench for approx_max_pipe; results are scored against a
// queue-based reference model computed from operand values at acceptance time.
module tb_approx_max_pipe;

    localparam int WIDTH   = 5;
    localparam int TRUNC   = 2;
    localparam int ERR_W   = 16;
    localparam int ERR_WS  = 2;
    localparam int SAT_MAX = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_last;
    logic             approx_en;
    logic             out_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             in_ready;
    logic             out_valid;
    logic             out_sel;
    logic             out_last;
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_frame_max;
    logic [ERR_W-1:0] err_cnt;

    logic              in_ready_s;
    logic              out_valid_s;
    logic              out_sel_s;
    logic              out_last_s;
    logic [WIDTH-1:0]  out_max_s;
    logic [WIDTH-1:0]  out_frame_max_s;
    logic [ERR_WS-1:0] err_cnt_s;

    always #5 clk = ~clk;

    approx_max_pipe #(.WIDTH(WIDTH), .TRUNC(TRUNC), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
        .out_sel(out_sel), .out_last(out_last), .out_frame_max(out_frame_max),
        .err_cnt(err_cnt)
    );

    approx_max_pipe #(.WIDTH(WIDTH), .TRUNC(TRUNC), .ERR_W(ERR_WS)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .approx_en(approx_en),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_max(out_max_s),
        .out_sel(out_sel_s), .out_last(out_last_s), .out_frame_max(out_frame_max_s),
        .err_cnt(err_cnt_s)
    );

    typedef struct {
        int max;
        int sel;
        int last;
        int fmax;
        int err;
    } beat_t;

    beat_t sb[$];
    beat_t log_q[$];
    int    errors = 0;
    int    checks = 0;
    int    m_acc  = 0;
    int    m_err  = 0;
    int    n_acc  = 0;

    function automatic int sat_err(input int n);
        return (n > SAT_MAX) ? SAT_MAX : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    // One cycle: drive at negedge, check settled outputs, then update the model.
    task automatic step(input bit v, input int a, input int b, input bit last,
                        input bit en, input bit ordy);
        beat_t e;
        beat_t obs;
        int    se, sa, sel, mx, upd;
        @(negedge clk);
        in_valid  = v;
        in_a      = WIDTH'(a);
        in_b      = WIDTH'(b);
        in_last   = last;
        approx_en = en;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, ((sb.size() < 2) || ordy) ? 1 : 0);
        chk("in_ready_sat", in_ready_s, ((sb.size() < 2) || ordy) ? 1 : 0);
        if (sb.size() == 0) begin
            chk("no_stale_out", out_valid, 0);
            chk("err_idle", err_cnt, m_err);
            chk("err_idle_sat", err_cnt_s, sat_err(m_err));
        end else if (out_valid) begin
            e = sb[0];
            chk("out_max", out_max, e.max);
            chk("out_sel", out_sel, e.sel);
            chk("out_last", out_last, e.last);
            chk("out_frame_max", out_frame_max, e.fmax);
            chk("err_cnt", err_cnt, e.err);
            chk("err_cnt_sat", err_cnt_s, sat_err(e.err));
            chk("out_valid_sat", out_valid_s, 1);
            if (ordy) begin
                obs.max  = int'(out_max);
                obs.sel  = int'(out_sel);
                obs.last = int'(out_last);
                obs.fmax = int'(out_frame_max);
                obs.err  = int'(err_cnt);
                log_q.push_back(obs);
                e = sb.pop_front();
            end
        end
        if (v && in_ready) begin
            se     = (b > a) ? 1 : 0;
            sa     = ((b >> TRUNC) > (a >> TRUNC)) ? 1 : 0;
            sel    = en ? sa : se;
            mx     = (sel != 0) ? b : a;
            upd    = en ? (((mx >> TRUNC) > (m_acc >> TRUNC)) ? 1 : 0) : ((mx > m_acc) ? 1 : 0);
            e.max  = mx;
            e.sel  = sel;
            e.last = last ? 1 : 0;
            e.fmax = (upd != 0) ? mx : m_acc;
            m_acc  = last ? 0 : e.fmax;
            if (en && (sa != se)) m_err++;
            e.err  = m_err;
            sb.push_back(e);
            n_acc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_max", out_max, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_max", out_frame_max, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_cnt_sat", err_cnt_s, 0);
        sb.delete();
        log_q.delete();
        m_acc = 0;
        m_err = 0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        approx_en = 1'b0;
        out_ready = 1'b1;
        do_reset();

        // exact compare, two-cycle latency
        step(1, 13, 14, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t1_latency_early", out_valid, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_max", out_max, 14);
        chk("t1_out_sel", out_sel, 1);
        chk("t1_err_cnt", err_cnt, 0);
        idle(2);

        // approx tie selects A and counts a mismatch
        do_reset();
        step(1, 13, 14, 0, 1, 1);
        idle(2);
        chk("t2_out_max", out_max, 13);
        chk("t2_out_sel", out_sel, 0);
        chk("t2_err_cnt", err_cnt, 1);
        idle(2);

        // frame max across two frames
        do_reset();
        step(1, 3, 7, 0, 0, 1);
        step(1, 20, 1, 0, 0, 1);
        step(1, 9, 9, 1, 0, 1);
        step(1, 2, 1, 1, 0, 1);
        idle(4);
        chk("t3_count", log_q.size(), 4);
        chk("t3_fmax0", log_q[0].fmax, 7);
        chk("t3_fmax1", log_q[1].fmax, 20);
        chk("t3_fmax2", log_q[2].fmax, 20);
        chk("t3_last2", log_q[2].last, 1);
        chk("t3_last1", log_q[1].last, 0);
        chk("t3_fmax3", log_q[3].fmax, 2);

        // backpressure: four stalled cycles, six beats in order
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 4; i++) step(1, 10 + n_acc, 3 * n_acc, 0, 0, 0);
        chk("t4_inready_low", in_ready, 0);
        chk("t4_held_count", n_acc, 2);
        for (int i = 0; i < 12 && n_acc < 6; i++) step(1, 10 + n_acc, 3 * n_acc, (n_acc == 5) ? 1 : 0, 0, 1);
        idle(4);
        chk("t4_out_count", log_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("t4_order", log_q[i].max, (10 + i > 3 * i) ? 10 + i : 3 * i);

        // saturation of the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 13, 14, 0, 1, 1);
        idle(3);
        chk("t5_sat", err_cnt_s, 3);
        chk("t5_wide", err_cnt, 5);
        for (int i = 0; i < 2; i++) step(1, 13, 14, 0, 1, 1);
        idle(3);
        chk("t5_sat_hold", err_cnt_s, 3);
        chk("t5_wide_more", err_cnt, 7);

        // reset mid-frame discards in-flight beats and partial max
        do_reset();
        step(1, 25, 3, 0, 1, 1);
        step(1, 1, 20, 0, 0, 1);
        do_reset();
        step(1, 4, 6, 1, 0, 1);
        idle(3);
        chk("t6_count", log_q.size(), 1);
        chk("t6_fmax", log_q[0].fmax, 6);
        chk("t6_err", log_q[0].err, 0);

        // randomized traffic with random backpressure
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 3) != 0));
        end
        idle(6);
        chk("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
